// File: rtl/dp_nway_pp_buffer_ctrl_pkg.sv
// Shared definitions for the N-way rotating ping-pong buffer controller:
// role encodings, index width and modular role-to-buffer helpers.
package dp_nway_pp_buffer_ctrl_pkg;

    localparam int COMMON_BRAM_DELAY = 2;
    localparam int BASE_W            = 3;

    // Role encodings double as bit positions in the pending-flag vector.
    typedef enum logic [1:0] {
        ROLE_LOAD = 2'd0,
        ROLE_NTT  = 2'd1,
        ROLE_MADD = 2'd2,
        ROLE_IDLE = 2'd3
    } role_e;

    function automatic logic [BASE_W-1:0] mod_idx(
        input logic [BASE_W-1:0] base,
        input logic [3:0]        off,
        input logic [3:0]        n
    );
        logic [4:0] sum;
        sum = {2'b00, base} + {1'b0, off};
        if (sum >= {1'b0, n}) begin
            sum = sum - {1'b0, n};
        end else begin
            sum = sum;
        end
        return sum[BASE_W-1:0];
    endfunction

    function automatic role_e role_of(
        input logic [BASE_W-1:0] buf_idx,
        input logic [BASE_W-1:0] base,
        input logic [3:0]        n
    );
        role_e role;
        if (buf_idx == base) begin
            role = ROLE_LOAD;
        end else if (buf_idx == mod_idx(base, n - 4'd1, n)) begin
            role = ROLE_NTT;
        end else if (buf_idx == mod_idx(base, n - 4'd2, n)) begin
            role = ROLE_MADD;
        end else begin
            role = ROLE_IDLE;
        end
        return role;
    endfunction

endpackage

// File: rtl/dp_nway_pp_buffer_ctrl_if.sv
// Role-side and buffer-side buses of the rotating buffer controller.
// slave = controller view, master = surrounding datapath / RAM view.
interface dp_nway_pp_buffer_ctrl_if #(
    parameter int COE_WIDTH  = 39,
    parameter int ADDR_WIDTH = 9,
    parameter int NUM_LANE   = 24,
    parameter int NUM_BUF    = 3
);
    localparam int DATA_V = COE_WIDTH * NUM_LANE;
    localparam int ADDR_V = ADDR_WIDTH * NUM_LANE;

    logic [NUM_LANE-1:0]         i_ntt_we;
    logic [ADDR_V-1:0]           i_ntt_wraddr;
    logic [ADDR_V-1:0]           i_ntt_rdaddr;
    logic [DATA_V-1:0]           i_ntt_data;
    logic [DATA_V-1:0]           o_ntt_data;

    logic [NUM_LANE-1:0]         i_ld_we;
    logic [ADDR_V-1:0]           i_ld_addr;
    logic [DATA_V-1:0]           i_ld_data;
    logic [ADDR_WIDTH-1:0]       i_tap_rdaddr;
    logic [DATA_V-1:0]           o_tap_data;

    logic [ADDR_V-1:0]           i_madd_rdaddr;
    logic [DATA_V-1:0]           o_madd_data;

    logic [NUM_BUF*NUM_LANE-1:0] o_buf_we;
    logic [NUM_BUF*ADDR_V-1:0]   o_buf_addra;
    logic [NUM_BUF*ADDR_V-1:0]   o_buf_addrb;
    logic [NUM_BUF*DATA_V-1:0]   o_buf_dina;
    logic [NUM_BUF*DATA_V-1:0]   i_buf_doutb;

    modport master (
        output i_ntt_we, i_ntt_wraddr, i_ntt_rdaddr, i_ntt_data,
        output i_ld_we, i_ld_addr, i_ld_data, i_tap_rdaddr,
        output i_madd_rdaddr, i_buf_doutb,
        input  o_ntt_data, o_tap_data, o_madd_data,
        input  o_buf_we, o_buf_addra, o_buf_addrb, o_buf_dina
    );

    modport slave (
        input  i_ntt_we, i_ntt_wraddr, i_ntt_rdaddr, i_ntt_data,
        input  i_ld_we, i_ld_addr, i_ld_data, i_tap_rdaddr,
        input  i_madd_rdaddr, i_buf_doutb,
        output o_ntt_data, o_tap_data, o_madd_data,
        output o_buf_we, o_buf_addra, o_buf_addrb, o_buf_dina
    );

endinterface

// File: rtl/dp_rd_sel_pipe.sv
// Delays the read-select word (base index plus tap-source flag) by the
// external RAM read latency so returning data is steered by the issuing base.
module dp_rd_sel_pipe
    import dp_nway_pp_buffer_ctrl_pkg::*;
#(
    parameter int W     = BASE_W + 1,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] i_sel,
    output logic [W-1:0] o_sel
);

    logic [W-1:0] r_pipe [DEPTH];

    // Shift register, cleared by synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_pipe[i] <= '0;
            end
        end else begin
            r_pipe[0] <= i_sel;
            for (int i = 1; i < DEPTH; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    assign o_sel = r_pipe[DEPTH-1];

endmodule

// File: rtl/dp_nway_pp_buffer_ctrl.sv
// Rotating N-way ping-pong buffer controller: LOAD/NTT/MADD roles walk across
// NUM_BUF external RAMs, advancing once all three roles report done.
module dp_nway_pp_buffer_ctrl
    import dp_nway_pp_buffer_ctrl_pkg::*;
#(
    parameter int COE_WIDTH  = 39,
    parameter int ADDR_WIDTH = 9,
    parameter int NUM_LANE   = 24,
    parameter int NUM_BUF    = 3,
    parameter int RD_LAT     = COMMON_BRAM_DELAY
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_load_done,
    input  logic                     i_ntt_done,
    input  logic                     i_madd_done,
    dp_nway_pp_buffer_ctrl_if.slave  bus,
    output logic [2:0]               o_base,
    output logic                     o_rot,
    output logic [15:0]              o_rot_cnt,
    output logic [2:0]               o_role_pend
);

    localparam int         DATA_V = COE_WIDTH * NUM_LANE;
    localparam int         ADDR_V = ADDR_WIDTH * NUM_LANE;
    localparam logic [3:0] NB     = 4'(NUM_BUF);

    logic [BASE_W-1:0] r_base;
    logic [2:0]        r_pend;
    logic [2:0]        r_done_prev;
    logic              r_rot;
    logic [15:0]       r_rot_cnt;

    logic [2:0]        w_done;
    logic [2:0]        w_edge;
    logic              w_all_pend;
    logic [BASE_W-1:0] w_base;
    logic              w_ntt_blk;
    logic [ADDR_V-1:0] w_tap_rep;
    logic [BASE_W:0]   w_sel_in;
    logic [BASE_W:0]   w_sel_d;
    logic [BASE_W-1:0] w_base_d;
    logic              w_tap_ntt_d;
    logic [BASE_W-1:0] w_ntt_idx_d;
    logic [BASE_W-1:0] w_madd_idx_d;

    assign w_done     = {i_madd_done, i_ntt_done, i_load_done};
    assign w_edge     = w_done & ~r_done_prev;
    assign w_all_pend = &r_pend;

    // Pending flags, base rotation and rotation counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_base      <= '0;
            r_pend      <= 3'b000;
            r_done_prev <= 3'b000;
            r_rot       <= 1'b0;
            r_rot_cnt   <= 16'd0;
        end else begin
            r_done_prev <= w_done;
            if (w_all_pend) begin
                // Edges landing on the rotation cycle belong to the new epoch.
                r_pend    <= w_edge;
                r_base    <= mod_idx(r_base, 4'd1, NB);
                r_rot     <= 1'b1;
                r_rot_cnt <= r_rot_cnt + 16'd1;
            end else begin
                r_pend    <= r_pend | w_edge;
                r_rot     <= 1'b0;
                r_rot_cnt <= r_rot_cnt;
            end
        end
    end

    assign o_base      = r_base;
    assign o_rot       = r_rot;
    assign o_rot_cnt   = r_rot_cnt;
    assign o_role_pend = r_pend;

    // While reset is held the muxes already behave as base 0 with no flags.
    assign w_base    = rst_n ? r_base : '0;
    assign w_ntt_blk = rst_n & r_pend[ROLE_NTT];
    assign w_tap_rep = {NUM_LANE{bus.i_tap_rdaddr}};

    // Per-buffer write/address steering from the current role map.
    always_comb begin
        bus.o_buf_we    = '0;
        bus.o_buf_addra = '0;
        bus.o_buf_addrb = '0;
        bus.o_buf_dina  = '0;
        for (int b = 0; b < NUM_BUF; b++) begin
            case (role_of(BASE_W'(b), w_base, NB))
                ROLE_LOAD: begin
                    bus.o_buf_we[b*NUM_LANE +: NUM_LANE] = bus.i_ld_we;
                    bus.o_buf_addra[b*ADDR_V +: ADDR_V]  = bus.i_ld_addr;
                    bus.o_buf_dina[b*DATA_V +: DATA_V]   = bus.i_ld_data;
                    bus.o_buf_addrb[b*ADDR_V +: ADDR_V]  = w_tap_rep;
                end
                ROLE_NTT: begin
                    bus.o_buf_we[b*NUM_LANE +: NUM_LANE] = w_ntt_blk ? '0 : bus.i_ntt_we;
                    bus.o_buf_addra[b*ADDR_V +: ADDR_V]  = bus.i_ntt_wraddr;
                    bus.o_buf_dina[b*DATA_V +: DATA_V]   = bus.i_ntt_data;
                    bus.o_buf_addrb[b*ADDR_V +: ADDR_V]  = w_ntt_blk ? w_tap_rep : bus.i_ntt_rdaddr;
                end
                ROLE_MADD: begin
                    bus.o_buf_we[b*NUM_LANE +: NUM_LANE] = '0;
                    bus.o_buf_addra[b*ADDR_V +: ADDR_V]  = '0;
                    bus.o_buf_dina[b*DATA_V +: DATA_V]   = '0;
                    bus.o_buf_addrb[b*ADDR_V +: ADDR_V]  = bus.i_madd_rdaddr;
                end
                default: begin
                    bus.o_buf_we[b*NUM_LANE +: NUM_LANE] = '0;
                    bus.o_buf_addra[b*ADDR_V +: ADDR_V]  = '0;
                    bus.o_buf_dina[b*DATA_V +: DATA_V]   = '0;
                    bus.o_buf_addrb[b*ADDR_V +: ADDR_V]  = '0;
                end
            endcase
        end
    end

    assign w_sel_in = {w_ntt_blk, w_base};

    dp_rd_sel_pipe #(
        .W     (BASE_W + 1),
        .DEPTH (RD_LAT)
    ) u_rd_sel_pipe (
        .clk   (clk),
        .rst_n (rst_n),
        .i_sel (w_sel_in),
        .o_sel (w_sel_d)
    );

    assign w_base_d     = w_sel_d[BASE_W-1:0];
    assign w_tap_ntt_d  = w_sel_d[BASE_W];
    assign w_ntt_idx_d  = mod_idx(w_base_d, NB - 4'd1, NB);
    assign w_madd_idx_d = mod_idx(w_base_d, NB - 4'd2, NB);

    // Read-data steering by the base that was current when the read issued.
    always_comb begin
        bus.o_ntt_data  = bus.i_buf_doutb[int'(w_ntt_idx_d) * DATA_V +: DATA_V];
        bus.o_madd_data = bus.i_buf_doutb[int'(w_madd_idx_d) * DATA_V +: DATA_V];
        if (w_tap_ntt_d) begin
            bus.o_tap_data = bus.i_buf_doutb[int'(w_ntt_idx_d) * DATA_V +: DATA_V];
        end else begin
            bus.o_tap_data = bus.i_buf_doutb[int'(w_base_d) * DATA_V +: DATA_V];
        end
    end

endmodule

// File: doc/dp_nway_pp_buffer_ctrl.md
DP_NWAY_PP_BUFFER_CTRL -- requirements
Module: dp_nway_pp_buffer_ctrl

Interface
REQ-001 SHALL have parameter COE_WIDTH, default 39: coefficient width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 9: per-lane bank address width.
REQ-003 SHALL have parameter NUM_LANE, default 24: banks per buffer (NUM_BASE_BANK*NUM_POLY).
REQ-004 SHALL have parameter NUM_BUF, default 3, legal range 3..8: number of rotating buffers.
REQ-005 SHALL have parameter RD_LAT, default COMMON_BRAM_DELAY, legal range 1..4: external RAM read latency in cycles.
REQ-006 SHALL have ports clk (in, 1, clock) and rst_n (in, 1, reset; synchronous, active-low).
REQ-007 SHALL have ports i_load_done, i_ntt_done and i_madd_done (in, 1 each): per-role job-complete level or pulse.
REQ-008 SHALL have NTT ports i_ntt_we [NUM_LANE], i_ntt_wraddr and i_ntt_rdaddr [ADDR_WIDTH*NUM_LANE], i_ntt_data [COE_WIDTH*NUM_LANE] (in), and o_ntt_data [COE_WIDTH*NUM_LANE] (out).
REQ-009 SHALL have load-role write ports i_ld_we [NUM_LANE], i_ld_addr [ADDR_WIDTH*NUM_LANE], i_ld_data [COE_WIDTH*NUM_LANE] (in) and tap-read ports i_tap_rdaddr [ADDR_WIDTH] (in), o_tap_data [COE_WIDTH*NUM_LANE] (out).
REQ-010 SHALL have MADD ports i_madd_rdaddr [ADDR_WIDTH*NUM_LANE] (in) and o_madd_data [COE_WIDTH*NUM_LANE] (out).
REQ-011 SHALL have buffer ports o_buf_we [NUM_BUF*NUM_LANE], o_buf_addra and o_buf_addrb [NUM_BUF*ADDR_WIDTH*NUM_LANE], o_buf_dina [NUM_BUF*COE_WIDTH*NUM_LANE] (out), and i_buf_doutb [NUM_BUF*COE_WIDTH*NUM_LANE] (in).
REQ-012 SHALL have status ports o_base [3] (buffer index held by LOAD), o_rot (1, rotation pulse), o_rot_cnt [16] (wrapping rotation count) and o_role_pend [3] (latched done flags, bit0 LOAD, bit1 NTT, bit2 MADD), all out.

Function
REQ-013 Roles SHALL map to buffers as LOAD=base, NTT=(base+NUM_BUF-1) mod NUM_BUF, MADD=(base+NUM_BUF-2) mod NUM_BUF; buffers holding no role are idle, with we=0, addra=0, dina=0, addrb=0.
REQ-014 A rising edge of each done input (registered previous value, 0 to 1) SHALL set that role's pending flag; a level held high SHALL NOT set it again.
REQ-015 When all three pending flags are set, the next clock SHALL do all of: clear the flags, set base=(base+1) mod NUM_BUF, pulse o_rot for 1 cycle, and increment o_rot_cnt (0xFFFF wraps to 0).
REQ-016 A done edge arriving in the same cycle as a rotation SHALL be credited to the new epoch: its flag is set after the clear.
REQ-017 A done edge for an already-pending role SHALL be ignored.
REQ-018 Write and address muxing to the buffers SHALL be combinational from the current base.
REQ-019 Read data SHALL be selected by a base copy delayed RD_LAT cycles, so a read issued before a rotation returns data from the buffer that was addressed.
REQ-020 LOAD buffer addrb SHALL be i_tap_rdaddr replicated NUM_LANE times, and o_tap_data SHALL be that buffer's doutb.
REQ-021 While the NTT pending flag is set, the NTT buffer addrb SHALL switch to the tap address and o_tap_data SHALL source the NTT buffer, giving early readout of finished NTT results; NTT writes SHALL be blocked while the flag is set.
REQ-022 The MADD buffer SHALL be read-only: we=0.
REQ-023 Outputs for unassigned roles SHALL be 0.

Reset
REQ-024 While rst_n=0 at a clk edge, the block SHALL set base=0, pending=0, o_rot=0, o_rot_cnt=0, the done-edge registers to 0, and the delayed base pipeline to 0.
REQ-025 Reset asserted mid-epoch SHALL discard pending flags; the first cycle after reset SHALL map LOAD=0, NTT=NUM_BUF-1, MADD=NUM_BUF-2.
REQ-026 Combinational outputs during reset SHALL reflect base=0.

Structure
REQ-027 The role encodings (ROLE_LOAD=0, ROLE_NTT=1, ROLE_MADD=2) and the modular-index function SHALL live in the shared dp_defines/dp package.
REQ-028 One sub-module, dp_rd_sel_pipe, SHALL be used: a RD_LAT-deep shift register of base index with reset.
REQ-029 Buffer RAMs SHALL remain external.

Verification
REQ-030 With NUM_BUF=3, pulse load, ntt and madd done in separate cycles -> one o_rot pulse one cycle after the third, o_base 0->1, o_rot_cnt=1.
REQ-031 With NUM_BUF=5, perform 5 rotations -> o_base sequence 1,2,3,4,0, and idle buffers always show we=0 and addr=0.
REQ-032 Hold i_ntt_done high across 2 epochs -> only the first edge counts, and with no second rotation o_role_pend[1]=0 after the first rotation.
REQ-033 Issue i_ntt_done on the rotation cycle -> o_role_pend=3'b010 in the new epoch.
REQ-034 With RD_LAT=2, issue an NTT read at address 5 one cycle before rotation -> o_ntt_data returns the old NTT buffer's value at address 5.
REQ-035 Assert rst_n=0 with two flags pending at base=2 -> after reset base=0, o_role_pend=0, o_rot_cnt=0.
